// File: rtl/lsu_pkg.sv
// Load/store unit shared types and helpers.
// func3 codes, error and state encodings, size decode.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_FAULT    = 2'b10,
    ERR_ILLEGAL  = 2'b11
  } lsu_err_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } lsu_state_e;

  // Access size in bytes: 1, 2, 4 or 8.
  function automatic logic [3:0] lsu_size(input logic [2:0] f3);
    return 4'd1 << f3[1:0];
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the load/store unit.
// Store strobes/data shift in, load data shift out and extend.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int NB = XLEN / 8,
  localparam int OFS_W = $clog2(NB)
) (
  input  logic [2:0]       st_func3_i,
  input  logic [OFS_W-1:0] st_ofs_i,
  input  logic [XLEN-1:0]  st_wdata_i,
  output logic [NB-1:0]    st_strb_o,
  output logic [XLEN-1:0]  st_wdata_o,
  input  logic [2:0]       ld_func3_i,
  input  logic [OFS_W-1:0] ld_ofs_i,
  input  logic [XLEN-1:0]  ld_rdata_i,
  output logic [XLEN-1:0]  ld_data_o
);

  logic [7:0]      mask;
  logic [XLEN-1:0] d;

  assign mask = 8'hFF >> (4'd8 - lsu_size(st_func3_i));
  assign st_strb_o = NB'(mask) << st_ofs_i;
  assign st_wdata_o = st_wdata_i << {st_ofs_i, 3'b000};
  assign d = ld_rdata_i >> {ld_ofs_i, 3'b000};

  // Extend the right-aligned load data by access type.
  always_comb begin
    ld_data_o = d;
    case (ld_func3_i)
      F3_B:    ld_data_o = XLEN'($signed(d[7:0]));
      F3_H:    ld_data_o = XLEN'($signed(d[15:0]));
      F3_W:    ld_data_o = XLEN'($signed(d[31:0]));
      F3_BU:   ld_data_o = XLEN'(d[7:0]);
      F3_HU:   ld_data_o = XLEN'(d[15:0]);
      F3_WU:   ld_data_o = XLEN'(d[31:0]);
      default: ld_data_o = d;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store engine on a ready/valid bus.
// Checks legality and alignment, then runs one bus access.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ADDR_W = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_func3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [XLEN/8-1:0] bus_wstrb,
  output logic [XLEN-1:0]   bus_wdata,
  input  logic [XLEN-1:0]   bus_rdata,
  input  logic              bus_ready,
  input  logic              bus_err
);

  localparam int NB = XLEN / 8;
  localparam int OFS_W = $clog2(NB);

  lsu_state_e        state_q, state_d;
  lsu_err_e          err_q, err_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [OFS_W-1:0]  ofs_q, ofs_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NB-1:0]     strb_q, strb_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic [31:0]       cnt_q, cnt_d;

  logic [OFS_W-1:0]  req_ofs;
  logic [3:0]        size_m1;
  logic              req_illegal;
  logic              req_misalign;
  logic              tmo_hit;
  logic [NB-1:0]     st_strb;
  logic [XLEN-1:0]   st_wdata;
  logic [XLEN-1:0]   ld_data;

  assign req_ofs = req_addr[OFS_W-1:0];
  assign size_m1 = lsu_size(req_func3) - 4'd1;

  assign req_illegal =
    (req_we && req_func3[2]) ||
    (!req_we && req_func3 == 3'b111) ||
    (XLEN == 32 &&
     (req_func3 == F3_D || req_func3 == F3_WU));

  assign req_misalign = |(4'(req_ofs) & size_m1);

  assign tmo_hit = (TIMEOUT_CYCLES != 0) &&
    (cnt_q == 32'(TIMEOUT_CYCLES - 1));

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .st_func3_i (req_func3),
    .st_ofs_i   (req_ofs),
    .st_wdata_i (req_wdata),
    .st_strb_o  (st_strb),
    .st_wdata_o (st_wdata),
    .ld_func3_i (f3_q),
    .ld_ofs_i   (ofs_q),
    .ld_rdata_i (bus_rdata),
    .ld_data_o  (ld_data)
  );

  // Next-state: accept/reject, bus completion, timeout.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    we_d    = we_q;
    f3_d    = f3_q;
    ofs_d   = ofs_q;
    addr_d  = addr_q;
    strb_d  = strb_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_func3;
          ofs_d   = req_ofs;
          addr_d  = {req_addr[ADDR_W-1:OFS_W],
                     OFS_W'(0)};
          strb_d  = req_we ? st_strb : '0;
          wdata_d = req_we ? st_wdata : '0;
          rdata_d = '0;
          cnt_d   = '0;
          if (req_illegal) begin
            err_d   = ERR_ILLEGAL;
            state_d = ST_RESP;
          end else if (req_misalign) begin
            err_d   = ERR_MISALIGN;
            state_d = ST_RESP;
          end else begin
            err_d   = ERR_OK;
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (bus_err) begin
          err_d   = ERR_FAULT;
          state_d = ST_RESP;
        end else if (bus_ready) begin
          rdata_d = we_q ? '0 : ld_data;
          state_d = ST_RESP;
        end else if (tmo_hit) begin
          err_d   = ERR_FAULT;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and request registers, async reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      err_q   <= ERR_OK;
      we_q    <= 1'b0;
      f3_q    <= '0;
      ofs_q   <= '0;
      addr_q  <= '0;
      strb_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      ofs_q   <= ofs_d;
      addr_q  <= addr_d;
      strb_q  <= strb_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign bus_req   = (state_q == ST_ACCESS);
  assign bus_we    = bus_req & we_q;
  assign bus_addr  = bus_req ? addr_q : '0;
  assign bus_wstrb = bus_req ? strb_q : '0;
  assign bus_wdata = bus_req ? wdata_q : '0;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_err   = rsp_valid ? err_q : ERR_OK;
  assign rsp_rdata = rsp_valid ? rdata_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit.
// 32-bit unit with a short timeout plus a 64-bit unit.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_func3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata, bus_rdata;
  logic        bus_ready, bus_err;

  logic        d_req_valid, d_req_ready, d_req_we;
  logic [2:0]  d_req_func3;
  logic [31:0] d_req_addr;
  logic [63:0] d_req_wdata;
  logic        d_rsp_valid;
  logic [63:0] d_rsp_rdata;
  logic [1:0]  d_rsp_err;
  logic        d_bus_req, d_bus_we;
  logic [31:0] d_bus_addr;
  logic [7:0]  d_bus_wstrb;
  logic [63:0] d_bus_wdata, d_bus_rdata;
  logic        d_bus_ready, d_bus_err;

  int nvec = 0;
  int nbad = 0;

  load_store_unit #(
    .XLEN(32), .ADDR_W(32), .TIMEOUT_CYCLES(4)
  ) u_dut32 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_func3(req_func3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ready(bus_ready), .bus_err(bus_err)
  );

  load_store_unit #(
    .XLEN(64), .ADDR_W(32), .TIMEOUT_CYCLES(255)
  ) u_dut64 (
    .clk(clk), .reset(reset),
    .req_valid(d_req_valid), .req_ready(d_req_ready),
    .req_we(d_req_we), .req_func3(d_req_func3),
    .req_addr(d_req_addr), .req_wdata(d_req_wdata),
    .rsp_valid(d_rsp_valid), .rsp_rdata(d_rsp_rdata),
    .rsp_err(d_rsp_err),
    .bus_req(d_bus_req), .bus_we(d_bus_we),
    .bus_addr(d_bus_addr), .bus_wstrb(d_bus_wstrb),
    .bus_wdata(d_bus_wdata), .bus_rdata(d_bus_rdata),
    .bus_ready(d_bus_ready), .bus_err(d_bus_err)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic txn(
    input string       tag,
    input logic        we,
    input logic [2:0]  f3,
    input logic [31:0] addr,
    input logic [31:0] wd,
    input logic [31:0] rd,
    input int          waits,
    input logic        berr,
    input int          xbus,
    input int          xlat,
    input logic [1:0]  xerr,
    input logic [31:0] xrd,
    input logic [3:0]  xstrb,
    input logic [31:0] xwd
  );
    int nb;
    int lat;
    logic [31:0] xa;
    nb = 0;
    lat = 0;
    xa = {addr[31:2], 2'b00};
    @(negedge clk);
    chk({tag, ".ready"}, req_ready, 1'b1);
    req_valid = 1'b1;
    req_we = we;
    req_func3 = f3;
    req_addr = addr;
    req_wdata = wd;
    @(posedge clk);
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      bus_ready = 1'b0;
      bus_err = 1'b0;
      bus_rdata = '0;
      if (bus_req) begin
        nb++;
        chk({tag, ".addr"}, bus_addr, xa);
        chk({tag, ".we"}, bus_we, we);
        chk({tag, ".strb"}, bus_wstrb, xstrb);
        if (we) chk({tag, ".wdata"}, bus_wdata, xwd);
        if (nb == waits + 1) begin
          bus_ready = 1'b1;
          bus_err = berr;
          bus_rdata = rd;
        end
      end
      if (rsp_valid) lat = k;
    end
    chk({tag, ".lat"}, lat, xlat);
    chk({tag, ".err"}, rsp_err, xerr);
    chk({tag, ".rdata"}, rsp_rdata, xrd);
    chk({tag, ".nbus"}, nb, xbus);
    @(negedge clk);
    bus_ready = 1'b0;
    bus_err = 1'b0;
    chk({tag, ".pulse"}, rsp_valid, 1'b0);
  endtask

  task automatic txn64(
    input string       tag,
    input logic        we,
    input logic [2:0]  f3,
    input logic [31:0] addr,
    input logic [63:0] wd,
    input logic [63:0] rd,
    input logic [31:0] xa,
    input logic [7:0]  xstrb,
    input logic [63:0] xwd,
    input logic [63:0] xrd
  );
    @(negedge clk);
    d_req_valid = 1'b1;
    d_req_we = we;
    d_req_func3 = f3;
    d_req_addr = addr;
    d_req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    d_req_valid = 1'b0;
    chk({tag, ".busreq"}, d_bus_req, 1'b1);
    chk({tag, ".addr"}, d_bus_addr, xa);
    chk({tag, ".strb"}, d_bus_wstrb, xstrb);
    if (we) chk({tag, ".wdata"}, d_bus_wdata, xwd);
    d_bus_ready = 1'b1;
    d_bus_rdata = rd;
    @(negedge clk);
    d_bus_ready = 1'b0;
    d_bus_rdata = '0;
    chk({tag, ".rsp"}, d_rsp_valid, 1'b1);
    chk({tag, ".err"}, d_rsp_err, 2'b00);
    chk({tag, ".rdata"}, d_rsp_rdata, xrd);
  endtask

  initial begin
    int seen;
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0;
    req_func3 = '0; req_addr = '0; req_wdata = '0;
    bus_rdata = '0; bus_ready = 1'b0; bus_err = 1'b0;
    d_req_valid = 1'b0; d_req_we = 1'b0;
    d_req_func3 = '0; d_req_addr = '0; d_req_wdata = '0;
    d_bus_rdata = '0; d_bus_ready = 1'b0; d_bus_err = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst.ready", req_ready, 1'b1);
    chk("rst.busreq", bus_req, 1'b0);
    chk("rst.rspv", rsp_valid, 1'b0);
    chk("rst.rsperr", rsp_err, 2'b00);
    chk("rst.rdata", rsp_rdata, 32'h0);
    chk("rst.strb", bus_wstrb, 4'h0);
    chk("rst.baddr", bus_addr, 32'h0);
    chk("rst.d_ready", d_req_ready, 1'b1);
    chk("rst.d_busreq", d_bus_req, 1'b0);

    // tag we f3 addr wd rd waits berr xbus xlat xerr xrd xstrb xwd
    txn("sw", 1, 3'b010, 32'h104, 32'hDEADBEEF, 0, 0, 0,
        1, 2, 2'b00, 0, 4'hF, 32'hDEADBEEF);
    txn("lb", 0, 3'b000, 32'h103, 0, 32'h80FF0000, 0, 0,
        1, 2, 2'b00, 32'hFFFFFF80, 4'h0, 0);
    txn("lhu", 0, 3'b101, 32'h102, 0, 32'h80FF0000, 0, 0,
        1, 2, 2'b00, 32'h000080FF, 4'h0, 0);
    txn("lh", 0, 3'b001, 32'h102, 0, 32'hFFFE0000, 0, 0,
        1, 2, 2'b00, 32'hFFFFFFFE, 4'h0, 0);
    txn("lbu", 0, 3'b100, 32'h101, 0, 32'h0000AB00, 0, 0,
        1, 2, 2'b00, 32'h000000AB, 4'h0, 0);
    txn("sb", 1, 3'b000, 32'h103, 32'h00000055, 0, 0, 0,
        1, 2, 2'b00, 0, 4'h8, 32'h55000000);
    txn("sh", 1, 3'b001, 32'h102, 32'h00001234, 0, 0, 0,
        1, 2, 2'b00, 0, 4'hC, 32'h12340000);
    txn("sh_mis", 1, 3'b001, 32'h101, 32'h1234, 0, 0, 0,
        0, 1, 2'b01, 0, 4'h0, 0);
    txn("lw_mis", 0, 3'b010, 32'h102, 0, 0, 0, 0,
        0, 1, 2'b01, 0, 4'h0, 0);
    txn("lw_wait", 0, 3'b010, 32'h100, 0, 32'h12345678, 3, 0,
        4, 5, 2'b00, 32'h12345678, 4'h0, 0);
    txn("lw_rdyerr", 0, 3'b010, 32'h108, 0, 32'hCAFEF00D, 0, 1,
        1, 2, 2'b10, 0, 4'h0, 0);
    txn("lw_tmo", 0, 3'b010, 32'h10C, 0, 0, 99, 0,
        4, 5, 2'b10, 0, 4'h0, 0);
    txn("ld32", 0, 3'b011, 32'h100, 0, 0, 0, 0,
        0, 1, 2'b11, 0, 4'h0, 0);
    txn("lwu32", 0, 3'b110, 32'h100, 0, 0, 0, 0,
        0, 1, 2'b11, 0, 4'h0, 0);
    txn("l111", 0, 3'b111, 32'h100, 0, 0, 0, 0,
        0, 1, 2'b11, 0, 4'h0, 0);
    txn("s100", 1, 3'b100, 32'h100, 0, 0, 0, 0,
        0, 1, 2'b11, 0, 4'h0, 0);
    txn("ill_mis", 1, 3'b110, 32'h101, 0, 0, 0, 0,
        0, 1, 2'b11, 0, 4'h0, 0);

    txn64("sb64", 1, 3'b000, 32'h7, 64'hA5, 0,
          32'h0, 8'h80, 64'hA500_0000_0000_0000, 0);
    txn64("lwu64", 0, 3'b110, 32'h4, 0,
          64'h89ABCDEF_00000000, 32'h0, 8'h00, 0,
          64'h00000000_89ABCDEF);
    txn64("lw64", 0, 3'b010, 32'h4, 0,
          64'h89ABCDEF_00000000, 32'h0, 8'h00, 0,
          64'hFFFFFFFF_89ABCDEF);
    txn64("ld64", 0, 3'b011, 32'h8, 0,
          64'h01234567_89ABCDEF, 32'h8, 8'h00, 0,
          64'h01234567_89ABCDEF);
    txn64("sd64", 1, 3'b011, 32'h10, 64'h11223344_55667788, 0,
          32'h10, 8'hFF, 64'h11223344_55667788, 0);

    // Reset in the middle of an access.
    @(negedge clk);
    req_valid = 1'b1;
    req_we = 1'b0;
    req_func3 = 3'b010;
    req_addr = 32'h200;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_mid.pre", bus_req, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid.busreq", bus_req, 1'b0);
    chk("rst_mid.ready", req_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("rst_mid.norsp", seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

endmodule
